muldiv_seq_ctrl: RTL
====================

Name: muldiv_seq_ctrl

Overview:
- Iterative MULT/MULTU/DIV/DIVU unit for the EX stage of the pipelined CPU.
- Owns one instance of the shared 32-bit ripple add/sub datapath (operands A and B, control Ctr: 0 = add, 1 = sub; carry-out Co).
- Sequences that datapath over a fixed 37-cycle schedule and writes the HI/LO result registers.
- Exposes a start/busy/done handshake plus a flush input for pipeline squash.

Parameters:
- WIDTH, 32: operand width. Only 32 is supported because the datapath instance is 32-bit.
- CNT_W, 6: width of the iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new operation; sampled only when ready.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- rs  in  32  multiplicand or dividend; sampled with start.
- rt  in  32  multiplier or divisor; sampled with start.
- flush  in  1  synchronous abort of the operation in flight.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when hi/lo update.
- hi  out  32  product[63:32] or remainder.
- lo  out  32  product[31:0] or quotient.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and operand registers cleared.
- Reset mid-operation aborts immediately with the same values.
- States: IDLE, ABS_A, ABS_B, RUN, FIX_LO, FIX_HI, DONE.
- Ready = state IDLE or DONE. If start=1 and flush=0 while ready, latch op/rs/rt and go to ABS_A. A start is ignored in every other state.
- ABS_A: if op is signed and rs[31]=1, load 0-rs via the datapath (A=0, B=rs, Ctr=1); otherwise load rs. Record sign_a.
- ABS_B: same treatment for rt; record sign_b. Set div0 = (rt==0) for divide ops. Clear counter.
- RUN, 32 cycles:
  - Multiply: unsigned shift-add. If the multiplier LSB is 1, the datapath adds the multiplicand to the upper accumulator (Ctr=0); Co becomes the shifted-in bit. The {acc,mplr} pair shifts right 1.
  - Divide: restoring. Shift {rem,quot} left 1, then compute rem-divisor (Ctr=1). If Co=1 (no borrow), take the difference and set quot bit=1; otherwise keep rem and set quot bit=0.
  - Counter increments each cycle; leave RUN when counter==31.
- FIX_LO:
  - Multiply with sign_a^sign_b=1: lo=0-lo; borrow captured from Co.
  - Divide with sign_a^sign_b=1 and div0=0: quotient is negated.
  - Otherwise the value passes unchanged.
- FIX_HI:
  - Multiply: hi=~hi+carry, completing the 64-bit negation.
  - Divide with sign_a=1 and div0=0: remainder is negated.
  - Otherwise the value passes unchanged.
- DONE: done=1 for exactly this cycle; hi/lo hold final values from this cycle onward; busy=0. A start in DONE is accepted (back-to-back operation).
- Timing: start in cycle 0 → busy=1 in cycles 1–36 → done=1 in cycle 37. Latency is fixed and independent of operand values or sign.
- Divide by zero: hi=original rs, lo=0xFFFF_FFFF for both DIV and DIVU. No sign fix is applied.
- Signed overflow 0x8000_0000 / -1: lo=0x8000_0000, hi=0 (two's-complement wrap, no exception).
- flush=1 in any busy state: next state IDLE; busy=0 next cycle; no done; hi/lo keep their pre-operation values.
- flush and start together while ready: flush wins and nothing starts.
- hi/lo are written only in DONE and are never visible mid-computation. Internal working registers are separate.

Optional Feature:
- Macro MULDIV_DIV0_FLAG_EN.
- Defined: adds output port div_zero (1 bit). It is high together with done when the completed op was DIV/DIVU with rt==0, 0 otherwise, and reset to 0.
- Undefined: port absent. Divide-by-zero result values are unchanged.

Test Plan:
- MULTU rs=0xFFFF_FFFF rt=0xFFFF_FFFF at cycle 0 → done in cycle 37, hi=0xFFFF_FFFE, lo=0x0000_0001, busy high cycles 1–36.
- MULT rs=0xFFFF_FFFD (-3) rt=7 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
- DIVU 100/7 → lo=14, hi=2. DIV rs=0xFFFF_FFF9 (-7) rt=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- DIVU 5/0 → hi=5, lo=0xFFFF_FFFF, div_zero=1 when MULDIV_DIV0_FLAG_EN is defined. DIV 0xFFFF_FFF6/0 → hi=0xFFFF_FFF6, lo=0xFFFF_FFFF.
- Start MULTU 3×4; pulse start with other operands in cycle 5 → ignored, result 12. Flush in cycle 10 of a second op → busy=0 in cycle 11, no done, hi/lo stay 0/12.
- rst_n low in cycle 20 of an op → hi=lo=0, busy=0 at once. After release, start in the DONE cycle of an op → second done exactly 37 cycles later.

Source files
------------

// File: rtl/muldiv_seq_ctrl.sv
// rtl/muldiv_seq_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer on one shared add/sub datapath
// Optional macro MULDIV_DIV0_FLAG_EN adds the div_zero output.
module muldiv_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ABS_A, S_ABS_B, S_RUN, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_mq, r_rs_orig, r_hi, r_lo;
  logic             r_sign_a, r_sign_b, r_div0, r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_dp_a, w_dp_b, w_dp_res, w_div_shift, w_abs_b;
  logic             w_dp_ctr, w_dp_co;
  logic [WIDTH:0]   w_dp_sum;
  logic             w_ready, w_busy, w_accept, w_is_div, w_is_signed, w_neg_q;

  // The single shared ripple add/sub: Ctr=1 subtracts, Co=1 means no borrow.
  assign w_dp_sum = {1'b0, w_dp_a} + {1'b0, (w_dp_ctr ? ~w_dp_b : w_dp_b)}
                  + {{WIDTH{1'b0}}, w_dp_ctr};
  assign w_dp_res = w_dp_sum[WIDTH-1:0];
  assign w_dp_co  = w_dp_sum[WIDTH];

  assign w_ready     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_busy      = !w_ready;
  assign w_accept    = w_ready && start && !flush;
  assign w_is_div    = r_op[1];
  assign w_is_signed = r_op[0];
  assign w_neg_q     = r_sign_a ^ r_sign_b;
  assign w_div_shift = {r_acc[WIDTH-2:0], r_mq[WIDTH-1]};
  assign w_abs_b     = (w_is_signed && r_b[WIDTH-1]) ? w_dp_res : r_b;

  assign busy = w_busy;
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_comb begin
    w_dp_a   = '0;
    w_dp_b   = '0;
    w_dp_ctr = 1'b0;
    case (r_state)
      S_ABS_A: begin w_dp_b = r_a; w_dp_ctr = 1'b1; end
      S_ABS_B: begin w_dp_b = r_b; w_dp_ctr = 1'b1; end
      S_RUN: begin
        if (w_is_div) begin
          w_dp_a = w_div_shift; w_dp_b = r_b; w_dp_ctr = 1'b1;
        end else begin
          w_dp_a = r_acc; w_dp_b = r_a;
        end
      end
      S_FIX_LO: begin w_dp_b = r_mq; w_dp_ctr = 1'b1; end
      S_FIX_HI: begin
        if (w_is_div) begin
          w_dp_b = r_acc; w_dp_ctr = 1'b1;
        end else begin
          w_dp_a = ~r_acc; w_dp_b = {{(WIDTH-1){1'b0}}, r_carry};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_accept ? S_ABS_A : S_IDLE;
      S_ABS_A:        w_next = S_ABS_B;
      S_ABS_B:        w_next = S_RUN;
      S_RUN:          w_next = (r_cnt == CNT_W'(WIDTH-1)) ? S_FIX_LO : S_RUN;
      S_FIX_LO:       w_next = S_FIX_HI;
      S_FIX_HI:       w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
    if (flush && w_busy) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_mq      <= '0;
      r_rs_orig <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_div0    <= 1'b0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op      <= op;
        r_a       <= rs;
        r_b       <= rt;
        r_rs_orig <= rs;
      end
      case (r_state)
        S_ABS_A: begin
          if (w_is_signed && r_a[WIDTH-1]) r_a <= w_dp_res;
          r_sign_a <= w_is_signed && r_a[WIDTH-1];
        end
        S_ABS_B: begin
          r_b      <= w_abs_b;
          r_sign_b <= w_is_signed && r_b[WIDTH-1];
          r_div0   <= w_is_div && (r_b == '0);
          r_cnt    <= '0;
          r_acc    <= '0;
          r_mq     <= w_is_div ? r_a : w_abs_b;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_is_div) begin
            // A set top bit before the shift means the 33-bit remainder exceeds any divisor.
            if (w_dp_co || r_acc[WIDTH-1]) begin
              r_acc <= w_dp_res;
              r_mq  <= {r_mq[WIDTH-2:0], 1'b1};
            end else begin
              r_acc <= w_div_shift;
              r_mq  <= {r_mq[WIDTH-2:0], 1'b0};
            end
          end else if (r_mq[0]) begin
            r_acc <= {w_dp_co, w_dp_res[WIDTH-1:1]};
            r_mq  <= {w_dp_res[0], r_mq[WIDTH-1:1]};
          end else begin
            r_acc <= {1'b0, r_acc[WIDTH-1:1]};
            r_mq  <= {r_acc[0], r_mq[WIDTH-1:1]};
          end
        end
        S_FIX_LO: begin
          r_carry <= w_dp_co;
          if (w_is_div && r_div0) r_mq <= '1;
          else if (w_neg_q)       r_mq <= w_dp_res;
        end
        S_FIX_HI: begin
          if (!flush) begin
            r_lo <= r_mq;
            if (w_is_div)
              r_hi <= r_div0 ? r_rs_orig : (r_sign_a ? w_dp_res : r_acc);
            else
              r_hi <= w_neg_q ? w_dp_res : r_acc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIV0_FLAG_EN
  logic r_div_zero;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div_zero <= 1'b0;
    else        r_div_zero <= (r_state == S_FIX_HI) && !flush && r_div0;
  end
  assign div_zero = r_div_zero;
`endif

endmodule
